// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause bit positions,
// exception codes and reset/write-mask constants.
package cp0_unit_pkg;

    typedef enum logic [4:0] {
        REG_COUNT   = 5'd9,
        REG_COMPARE = 5'd11,
        REG_STATUS  = 5'd12,
        REG_CAUSE   = 5'd13,
        REG_EPC     = 5'd14,
        REG_PRID    = 5'd15,
        REG_CONFIG  = 5'd16
    } cp0_reg_e;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C
    } exc_code_e;

    localparam int STATUS_IE       = 0;
    localparam int STATUS_EXL      = 1;
    localparam int STATUS_IM_LSB   = 8;
    localparam int CAUSE_EXC_LSB   = 2;
    localparam int CAUSE_IP_LSB    = 8;
    localparam int CAUSE_HW_IP_LSB = 10;
    localparam int CAUSE_WP        = 22;
    localparam int CAUSE_IV        = 23;
    localparam int CAUSE_BD        = 31;

    localparam logic [31:0] STATUS_RST   = 32'h1000_0000;
    localparam logic [31:0] STATUS_WMASK = 32'hF3FF_FFFF;
    localparam logic [31:0] CAUSE_WMASK  = 32'h00C0_0300;

    function automatic logic [31:0] merge_bits(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// Pipeline-to-CP0 bus: register access plus exception/ERET commit strobes.
interface cp0_unit_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic        exc_bd_i;
    logic        eret_i;

    modport master (
        output we_i, waddr_i, wdata_i, raddr_i,
        output exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, eret_i,
        input  rdata_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr_i,
        input  exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, eret_i,
        output rdata_o
    );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer with prescaler and sticky timer interrupt flag.
module cp0_timer #(
    parameter int COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic [4:0] presc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            compare   <= '0;
            presc     <= '0;
            timer_int <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                presc <= '0;
            end else if (presc == 5'(COUNT_DIV - 1)) begin
                count <= count + 32'd1;
                presc <= '0;
            end else begin
                presc <= presc + 5'd1;
            end

            // A Compare write acknowledges the interrupt and beats a coincident match.
            if (compare_we) begin
                compare   <= wdata;
                timer_int <= 1'b0;
            end else if (count == compare && compare != '0) begin
                timer_int <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_unit.sv
// CP0 system control coprocessor: Status, Cause, EPC, PRId, Config, read
// forwarding, exception/ERET commit and interrupt request generation.
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter int          NUM_HW_INT     = 6,
    parameter int          TIMER_IRQ_LINE = 5,
    parameter int          COUNT_DIV      = 1,
    parameter logic [31:0] PRID_VAL       = 32'h004C0102,
    parameter logic [31:0] CONFIG_VAL     = 32'h00008000
) (
    input  logic                  clk,
    input  logic                  rst,
    cp0_unit_if.slave             bus,
    input  logic [NUM_HW_INT-1:0] int_i,
    output logic [31:0]           count_o,
    output logic [31:0]           compare_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  timer_int_o,
    output logic                  int_req_o
);

    logic [31:0] status_q, cause_q, epc_q;
    logic [5:0]  hw_ip;
    logic [31:0] rd_val;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    assign wr_count   = bus.we_i && (bus.waddr_i == REG_COUNT);
    assign wr_compare = bus.we_i && (bus.waddr_i == REG_COMPARE);
    assign wr_status  = bus.we_i && (bus.waddr_i == REG_STATUS);
    assign wr_cause   = bus.we_i && (bus.waddr_i == REG_CAUSE);
    assign wr_epc     = bus.we_i && (bus.waddr_i == REG_EPC);

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr_count),
        .compare_we (wr_compare),
        .wdata      (bus.wdata_i),
        .count      (count_o),
        .compare    (compare_o),
        .timer_int  (timer_int_o)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        hw_ip                 = '0;
        hw_ip[NUM_HW_INT-1:0] = int_i;
        hw_ip[TIMER_IRQ_LINE] = hw_ip[TIMER_IRQ_LINE] | timer_int_o;
    end

    // Hardware IP bits are live; cause_q holds only the software-visible fields.
    assign cause_o  = cause_q | {16'd0, hw_ip, 10'd0};
    assign status_o = status_q;
    assign epc_o    = epc_q;

    // Field priority is exception > ERET > software write, so later NBAs win.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q  <= STATUS_RST;
            cause_q   <= '0;
            epc_q     <= '0;
            int_req_o <= 1'b0;
        end else begin
            if (wr_status) status_q <= bus.wdata_i & STATUS_WMASK;
            if (wr_cause)  cause_q  <= merge_bits(cause_q, bus.wdata_i, CAUSE_WMASK);
            if (wr_epc)    epc_q    <= bus.wdata_i;

            if (bus.exc_valid_i) begin
                cause_q[CAUSE_EXC_LSB +: 5] <= bus.exc_code_i;
                if (!status_q[STATUS_EXL]) begin
                    status_q[STATUS_EXL] <= 1'b1;
                    cause_q[CAUSE_BD]    <= bus.exc_bd_i;
                    epc_q <= bus.exc_bd_i ? bus.exc_pc_i - 32'd4 : bus.exc_pc_i;
                end
            end else if (bus.eret_i) begin
                status_q[STATUS_EXL] <= 1'b0;
            end

            int_req_o <= status_q[STATUS_IE] & ~status_q[STATUS_EXL] &
                         (|(cause_o[CAUSE_IP_LSB +: 8] & status_q[STATUS_IM_LSB +: 8]));
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus.raddr_i)
            REG_COUNT:   rd_val = count_o;
            REG_COMPARE: rd_val = compare_o;
            REG_STATUS:  rd_val = status_q;
            REG_CAUSE:   rd_val = cause_o;
            REG_EPC:     rd_val = epc_q;
            REG_PRID:    rd_val = PRID_VAL;
            REG_CONFIG:  rd_val = CONFIG_VAL;
            default:     rd_val = '0;
        endcase
        // Same-cycle write to the register being read is forwarded.
        if (bus.we_i && bus.waddr_i == bus.raddr_i) begin
            case (bus.waddr_i)
                REG_COUNT, REG_COMPARE, REG_EPC: rd_val = bus.wdata_i;
                REG_STATUS: rd_val = bus.wdata_i & STATUS_WMASK;
                REG_CAUSE:  rd_val = merge_bits(cause_o, bus.wdata_i, CAUSE_WMASK);
                default:    ;
            endcase
        end
    end

    assign bus.rdata_o = rd_val;

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: directed scenarios then random traffic,
// checked against a field-level reference model.
module tb_cp0_unit;
    import cp0_unit_pkg::*;

    localparam int          NUM_HW_INT     = 6;
    localparam int          TIMER_IRQ_LINE = 5;
    localparam int          COUNT_DIV      = 2;
    localparam logic [31:0] PRID           = 32'h004C0102;
    localparam logic [31:0] CONFIG         = 32'h00008000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cp0_unit_if bus();
    logic [NUM_HW_INT-1:0] int_i;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o;
    logic        timer_int_o, int_req_o;

    cp0_unit #(
        .NUM_HW_INT     (NUM_HW_INT),
        .TIMER_IRQ_LINE (TIMER_IRQ_LINE),
        .COUNT_DIV      (COUNT_DIV),
        .PRID_VAL       (PRID),
        .CONFIG_VAL     (CONFIG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .int_i       (int_i),
        .count_o     (count_o),
        .compare_o   (compare_o),
        .status_o    (status_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o),
        .timer_int_o (timer_int_o),
        .int_req_o   (int_req_o)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [5:0]  irq;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        bd;
        logic        eret;
    } stim_t;

    typedef struct {
        logic [31:0] rdata, count, compare, status, cause, epc;
        logic        timer, intr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: Count is derived from elapsed cycles since its last write.
    logic [31:0] m_base, m_compare, m_status, m_epc;
    int unsigned m_cyc;
    logic        m_timer, m_intr, m_bd, m_iv, m_wp;
    logic [1:0]  m_swip;
    logic [4:0]  m_excc;
    logic [5:0]  cur_irq = '0;

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_cyc / COUNT_DIV);
    endfunction

    function automatic logic [31:0] m_cause(input logic [5:0] irq);
        logic [5:0] hw;
        hw = irq;
        hw[TIMER_IRQ_LINE] = hw[TIMER_IRQ_LINE] | m_timer;
        return {m_bd, 7'd0, m_iv, m_wp, 6'd0, hw, m_swip, 1'b0, m_excc, 2'b00};
    endfunction

    function automatic logic [31:0] m_read(input stim_t s);
        logic [31:0] v;
        case (s.raddr)
            5'd9:    v = m_count();
            5'd11:   v = m_compare;
            5'd12:   v = m_status;
            5'd13:   v = m_cause(s.irq);
            5'd14:   v = m_epc;
            5'd15:   v = PRID;
            5'd16:   v = CONFIG;
            default: v = 32'd0;
        endcase
        if (s.we && s.waddr == s.raddr) begin
            case (s.waddr)
                5'd9, 5'd11, 5'd14: v = s.wdata;
                5'd12: begin v = s.wdata; v[27:26] = 2'b00; end
                5'd13: begin v[23] = s.wdata[23]; v[22] = s.wdata[22]; v[9:8] = s.wdata[9:8]; end
                default: ;
            endcase
        end
        return v;
    endfunction

    task automatic m_reset();
        m_base = '0; m_cyc = 0; m_compare = '0; m_status = 32'h1000_0000; m_epc = '0;
        m_timer = 1'b0; m_intr = 1'b0; m_bd = 1'b0; m_iv = 1'b0; m_wp = 1'b0;
        m_swip = '0; m_excc = '0;
    endtask

    task automatic model_step(input stim_t s);
        logic [31:0] cnt, cause_now;
        logic        old_exl, intr_next;
        cnt       = m_count();
        cause_now = m_cause(s.irq);
        old_exl   = m_status[1];
        intr_next = m_status[0] & ~m_status[1] & (|(cause_now[15:8] & m_status[15:8]));

        if (s.we && s.waddr == 5'd11) begin
            m_compare = s.wdata;
            m_timer   = 1'b0;
        end else if (cnt == m_compare && m_compare != 0) begin
            m_timer = 1'b1;
        end

        if (s.we && s.waddr == 5'd9) begin
            m_base = s.wdata;
            m_cyc  = 0;
        end else begin
            m_cyc++;
        end

        if (s.we) begin
            case (s.waddr)
                5'd12: begin m_status = s.wdata; m_status[27:26] = 2'b00; end
                5'd13: begin m_iv = s.wdata[23]; m_wp = s.wdata[22]; m_swip = s.wdata[9:8]; end
                5'd14: m_epc = s.wdata;
                default: ;
            endcase
        end

        if (s.exc) begin
            m_excc = s.code;
            if (!old_exl) begin
                m_status[1] = 1'b1;
                m_bd        = s.bd;
                m_epc       = s.bd ? s.pc - 32'd4 : s.pc;
            end
        end else if (s.eret) begin
            m_status[1] = 1'b0;
        end

        m_intr = intr_next;
    endtask

    function automatic logic [4:0] rand_reg();
        case ($urandom_range(0, 8))
            0: return 5'd9;
            1: return 5'd11;
            2: return 5'd12;
            3: return 5'd13;
            4: return 5'd14;
            5: return 5'd15;
            6: return 5'd16;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.we = 1'b0; s.waddr = '0; s.wdata = '0; s.raddr = rand_reg(); s.irq = cur_irq;
        s.exc = 1'b0; s.code = '0; s.pc = '0; s.bd = 1'b0; s.eret = 1'b0;
        return s;
    endfunction

    function automatic stim_t wr(input logic [4:0] addr, input logic [31:0] data);
        stim_t s;
        s = idle();
        s.we = 1'b1; s.waddr = addr; s.wdata = data;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        if ($urandom_range(0, 15) == 0) cur_irq = 6'($urandom);
        s = idle();
        s.we    = ($urandom_range(0, 2) == 0);
        s.waddr = rand_reg();
        s.wdata = $urandom;
        if (s.waddr == 5'd11 && $urandom_range(0, 1) == 1) s.wdata = m_count() + 32'($urandom_range(0, 8));
        if (s.waddr == 5'd9 && $urandom_range(0, 1) == 1)  s.wdata = m_compare - 32'($urandom_range(0, 8));
        if ($urandom_range(0, 1) == 1) s.raddr = s.waddr;
        s.exc  = ($urandom_range(0, 7) == 0);
        s.code = 5'($urandom);
        s.pc   = $urandom;
        s.bd   = 1'($urandom);
        s.eret = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.we_i = s.we; bus.waddr_i = s.waddr; bus.wdata_i = s.wdata; bus.raddr_i = s.raddr;
        int_i = s.irq[NUM_HW_INT-1:0];
        bus.exc_valid_i = s.exc; bus.exc_code_i = s.code; bus.exc_pc_i = s.pc;
        bus.exc_bd_i = s.bd; bus.eret_i = s.eret;
    endtask

    // Apply one cycle of stimulus, queue the outputs expected during that
    // cycle, then advance the model across the following edge.
    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        e.rdata   = m_read(s);
        e.count   = m_count();
        e.compare = m_compare;
        e.status  = m_status;
        e.cause   = m_cause(s.irq);
        e.epc     = m_epc;
        e.timer   = m_timer;
        e.intr    = m_intr;
        sb.push_back(e);
        model_step(s);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rdata",     bus.rdata_o, e.rdata);
                check("count",     count_o,     e.count);
                check("compare",   compare_o,   e.compare);
                check("status",    status_o,    e.status);
                check("cause",     cause_o,     e.cause);
                check("epc",       epc_o,       e.epc);
                check("timer_int", 32'(timer_int_o), 32'(e.timer));
                check("int_req",   32'(int_req_o),   32'(e.intr));
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        apply(idle());
        #22;
        rst = 1'b1;
        m_reset();
        model_step(idle());

        // Timer: Compare=10 from Count=0 with divide-by-2, then acknowledge.
        drive(wr(5'd9, 32'd0));
        s = wr(5'd11, 32'd10); s.raddr = 5'd13; drive(s);
        repeat (24) drive(idle());
        drive(wr(5'd11, 32'd20));
        repeat (2) drive(idle());

        // Interrupt request from IP2 with IE, masked once EXL is set.
        cur_irq = 6'b000001;
        drive(idle());
        drive(wr(5'd12, 32'h0000_FF01));
        repeat (2) drive(idle());
        drive(wr(5'd12, 32'h0000_FF03));
        repeat (2) drive(idle());

        // Exception in a delay slot, then a nested exception.
        drive(wr(5'd12, 32'h0000_FF00));
        s = idle(); s.exc = 1'b1; s.code = 5'h0C; s.pc = 32'h8000_1000; s.bd = 1'b1; drive(s);
        drive(idle());
        s = idle(); s.exc = 1'b1; s.code = 5'h04; s.pc = 32'h0000_2000; s.bd = 1'b0; drive(s);
        drive(idle());

        // ERET, then exception colliding with an EPC write, then ERET.
        s = idle(); s.eret = 1'b1; drive(s);
        s = wr(5'd14, 32'h0000_1234); s.raddr = 5'd14;
        s.exc = 1'b1; s.code = 5'h0C; s.pc = 32'h8000_0100; drive(s);
        drive(idle());
        s = idle(); s.eret = 1'b1; s.raddr = 5'd12; drive(s);
        drive(idle());

        // Forwarded Cause write and ignored PRId write.
        s = wr(5'd13, 32'hFFFF_FFFF); s.raddr = 5'd13; drive(s);
        s = wr(5'd15, 32'hFFFF_FFFF); s.raddr = 5'd15; drive(s);
        drive(idle());

        // Asynchronous reset with Count at 37, with activity held during reset.
        cur_irq = '0;
        drive(wr(5'd9, 32'd37));
        drive(idle());
        @(negedge clk);
        #1;
        check("count_before_reset", count_o, 32'd37);
        rst = 1'b0;
        #1;
        check("rst_count",     count_o,   32'd0);
        check("rst_compare",   compare_o, 32'd0);
        check("rst_status",    status_o,  32'h1000_0000);
        check("rst_cause",     cause_o,   32'd0);
        check("rst_epc",       epc_o,     32'd0);
        check("rst_timer_int", 32'(timer_int_o), 32'd0);
        check("rst_int_req",   32'(int_req_o),   32'd0);
        s = wr(5'd14, 32'hDEAD_BEEF); s.exc = 1'b1; s.pc = 32'h1000; apply(s);
        @(posedge clk);
        #1;
        check("rst_hold_epc",    epc_o,    32'd0);
        check("rst_hold_status", status_o, 32'h1000_0000);
        check("rst_hold_count",  count_o,  32'd0);
        s = idle();
        apply(s);
        #2;
        rst = 1'b1;
        m_reset();
        model_step(s);

        repeat (600) drive(rand_stim());

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
